// File: rtl/sort3_pkg.sv
// Shared definitions for the sequential 3-value sorter: default width,
// FSM state encoding and sort-direction constants.
package sort3_pkg;

    localparam int WIDTH_DEF = 8;

    // Binary state encoding for the sort controller.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_P01A = 3'd1,
        ST_P12  = 3'd2,
        ST_P01B = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam logic DIR_ASC  = 1'b0;
    localparam logic DIR_DESC = 1'b1;

endpackage

// File: rtl/sort3_cmp_swap.sv
// Single compare-and-swap cell shared by all three sort passes.
// Equal operands never swap, which keeps the overall sort stable.
module sort3_cmp_swap
    import sort3_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    input  logic             dir,
    output logic [WIDTH-1:0] out_lo,
    output logic [WIDTH-1:0] out_hi,
    output logic             swapped
);

    // Decide whether the pair is out of order for the requested direction.
    always_comb begin
        swapped = 1'b0;
        if (dir == DIR_DESC) begin
            swapped = (lo < hi);
        end else begin
            swapped = (lo > hi);
        end
    end

    assign out_lo = swapped ? hi : lo;
    assign out_hi = swapped ? lo : hi;

endmodule

// File: rtl/sort3_seq_ctrl.sv
// Multi-cycle 3-value sorter: one compare-and-swap cell is reused over
// three passes (pair 0-1, pair 1-2, pair 0-1), giving a bubble sort of
// three elements with a 3-cycle latency.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. in_ready is high only in IDLE; out_valid is high only in DONE,
// and W/X/Y/SWAPS stay stable until the edge where out_ready is seen.
// Both ready/valid outputs decode from state, so neither depends
// combinationally on in_valid or out_ready.
module sort3_seq_ctrl
    import sort3_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    input  logic             DESC,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] W,
    output logic [WIDTH-1:0] X,
    output logic [WIDTH-1:0] Y,
    output logic [1:0]       SWAPS
);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] r0;
    logic [WIDTH-1:0] r1;
    logic [WIDTH-1:0] r2;
    logic             dir_q;
    logic [1:0]       swaps_q;

    logic [WIDTH-1:0] cs_lo;
    logic [WIDTH-1:0] cs_hi;
    logic [WIDTH-1:0] cs_out_lo;
    logic [WIDTH-1:0] cs_out_hi;
    logic             cs_swapped;

    // Route pair 1-2 into the shared cell during P12, pair 0-1 otherwise.
    always_comb begin
        cs_lo = r0;
        cs_hi = r1;
        if (state_q == ST_P12) begin
            cs_lo = r1;
            cs_hi = r2;
        end
    end

    sort3_cmp_swap #(
        .WIDTH (WIDTH)
    ) u_cmp_swap (
        .lo      (cs_lo),
        .hi      (cs_hi),
        .dir     (dir_q),
        .out_lo  (cs_out_lo),
        .out_hi  (cs_out_hi),
        .swapped (cs_swapped)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state sequencing through the three passes and the hold state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_valid) state_d = ST_P01A;
            ST_P01A: state_d = ST_P12;
            ST_P12:  state_d = ST_P01B;
            ST_P01B: state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand load on accept, then write back the cell result each pass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r0      <= '0;
            r1      <= '0;
            r2      <= '0;
            dir_q   <= DIR_ASC;
            swaps_q <= 2'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        r0      <= A;
                        r1      <= B;
                        r2      <= C;
                        dir_q   <= DESC;
                        swaps_q <= 2'd0;
                    end
                end
                ST_P01A, ST_P01B: begin
                    r0      <= cs_out_lo;
                    r1      <= cs_out_hi;
                    swaps_q <= swaps_q + {1'b0, cs_swapped};
                end
                ST_P12: begin
                    r1      <= cs_out_lo;
                    r2      <= cs_out_hi;
                    swaps_q <= swaps_q + {1'b0, cs_swapped};
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign W         = r0;
    assign X         = r1;
    assign Y         = r2;
    assign SWAPS     = swaps_q;

endmodule

// File: tb/tb_sort3_seq_ctrl.sv
// Self-checking bench for sort3_seq_ctrl: directed scenarios plus a
// randomized run, results checked through an expected-result queue.
module tb_sort3_seq_ctrl;

    localparam int WD = 8;
    localparam int RW = 3 * WD + 2;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [WD-1:0] A;
    logic [WD-1:0] B;
    logic [WD-1:0] C;
    logic          DESC;
    logic          out_valid;
    logic          out_ready;
    logic [WD-1:0] W;
    logic [WD-1:0] X;
    logic [WD-1:0] Y;
    logic [1:0]    SWAPS;

    logic [RW-1:0] exp_q[$];
    logic [RW-1:0] mon_got;
    logic [RW-1:0] mon_exp;
    int            n_cmp;
    int            n_err;

    sort3_seq_ctrl #(.WIDTH(WD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .C         (C),
        .DESC      (DESC),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .W         (W),
        .X         (X),
        .Y         (Y),
        .SWAPS     (SWAPS)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    // Sorted values from min/max; swap count = number of out-of-order pairs.
    function automatic logic [RW-1:0] model(input logic [WD-1:0] a, input logic [WD-1:0] b,
                                            input logic [WD-1:0] c, input logic d);
        logic [WD-1:0] v[3];
        logic [WD-1:0] mn, mx, md;
        int            inv;
        v[0] = a; v[1] = b; v[2] = c;
        mn = a; mx = a;
        for (int i = 1; i < 3; i++) begin
            if (v[i] < mn) mn = v[i];
            if (v[i] > mx) mx = v[i];
        end
        md = WD'((10'(a) + 10'(b) + 10'(c)) - 10'(mn) - 10'(mx));
        inv = 0;
        for (int i = 0; i < 3; i++)
            for (int j = i + 1; j < 3; j++)
                if (d ? (v[i] < v[j]) : (v[i] > v[j])) inv++;
        if (d) return {mx, md, mn, 2'(inv)};
        return {mn, md, mx, 2'(inv)};
    endfunction

    // ---------------- scoreboard monitor ----------------
    // Sampled on the falling edge: a result is consumed at the next rising edge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            mon_got = {W, X, Y, SWAPS};
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_output got W=%0d X=%0d Y=%0d SWAPS=%0d with nothing expected",
                         W, X, Y, SWAPS);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    n_err++;
                    $display("FAIL result got W=%0d X=%0d Y=%0d SWAPS=%0d expected W=%0d X=%0d Y=%0d SWAPS=%0d",
                             W, X, Y, SWAPS, mon_exp[RW-1 -: WD], mon_exp[RW-1-WD -: WD],
                             mon_exp[RW-1-2*WD -: WD], mon_exp[1:0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present operands for one accepted transfer; returns 1 time unit after the accept edge.
    task automatic send(input logic [WD-1:0] a, input logic [WD-1:0] b,
                        input logic [WD-1:0] c, input logic d);
        int k;
        k = 0;
        while (!in_ready && k < 50) begin
            step();
            k++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout in_ready=%0d required 1", in_ready);
        end
        A = a; B = b; C = c; DESC = d;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    // Wait until every expected result has been consumed.
    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 100) begin
            step();
            k++;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain_timeout pending=%0d required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        A = '0; B = '0; C = '0; DESC = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || {W, X, Y} !== '0 || SWAPS !== 2'd0) begin
            n_err++;
            $display("FAIL reset_values out_valid=%0d W=%0d X=%0d Y=%0d SWAPS=%0d required all 0",
                     out_valid, W, X, Y, SWAPS);
        end
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        step();
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release in_ready=%0d out_valid=%0d required 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_basic_latency();
        out_ready = 1'b1;
        exp_q.push_back({8'd7, 8'd10, 8'd15, 2'd2});
        send(8'd10, 8'd15, 8'd7, 1'b0);
        for (int i = 1; i <= 2; i++) begin
            step();
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL early_valid cycle t+%0d out_valid=%0d required 0", i, out_valid);
            end
        end
        step();
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL latency cycle t+3 out_valid=%0d required 1", out_valid);
        end
        drain();
    endtask

    task automatic test_in_ready_window();
        out_ready = 1'b1;
        exp_q.push_back({8'd5, 8'd15, 8'd71, 2'd0});
        send(8'd5, 8'd15, 8'd71, 1'b0);
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL busy_in_ready cycle t+%0d in_ready=%0d required 0", i, in_ready);
            end
            step();
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL idle_in_ready cycle t+4 in_ready=%0d required 1", in_ready);
        end
        drain();
    endtask

    task automatic test_desc_and_equal();
        out_ready = 1'b1;
        exp_q.push_back({8'd50, 8'd1, 8'd0, 2'd3});
        send(8'd0, 8'd1, 8'd50, 1'b1);
        drain();
        exp_q.push_back({8'd9, 8'd9, 8'd9, 2'd0});
        send(8'd9, 8'd9, 8'd9, 1'b0);
        drain();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        exp_q.push_back({8'd3, 8'd100, 8'd200, 2'd2});
        send(8'd200, 8'd3, 8'd100, 1'b0);
        A = 8'd1; B = 8'd2; C = 8'd3; DESC = 1'b0;
        in_valid = 1'b1;
        repeat (3) step();
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || W !== 8'd3 || X !== 8'd100 ||
                Y !== 8'd200 || SWAPS !== 2'd2) begin
                n_err++;
                $display("FAIL hold cycle %0d out_valid=%0d in_ready=%0d W=%0d X=%0d Y=%0d SWAPS=%0d required 1/0/3/100/200/2",
                         i, out_valid, in_ready, W, X, Y, SWAPS);
            end
            step();
        end
        exp_q.push_back({8'd1, 8'd2, 8'd3, 2'd0});
        out_ready = 1'b1;
        step();
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL release_idle in_ready=%0d out_valid=%0d required 1/0", in_ready, out_valid);
        end
        step();
        in_valid = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL pending_accept in_ready=%0d required 0", in_ready);
        end
        drain();
    endtask

    task automatic test_reset_midop();
        out_ready = 1'b1;
        send(8'd50, 8'd60, 8'd70, 1'b0);
        step();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || {W, X, Y} !== '0 || SWAPS !== 2'd0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL midop_reset out_valid=%0d W=%0d X=%0d Y=%0d SWAPS=%0d in_ready=%0d required 0/0/0/0/0/1",
                     out_valid, W, X, Y, SWAPS, in_ready);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            n_cmp++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL post_reset cycle %0d out_valid=%0d in_ready=%0d required 0/1", i, out_valid, in_ready);
            end
        end
        exp_q.push_back({8'd0, 8'd128, 8'd255, 2'd2});
        send(8'd255, 8'd0, 8'd128, 1'b0);
        drain();
    endtask

    task automatic test_operand_change();
        out_ready = 1'b1;
        exp_q.push_back({8'd7, 8'd10, 8'd15, 2'd2});
        send(8'd10, 8'd15, 8'd7, 1'b0);
        A = 8'd200; B = 8'd1; C = 8'd99; DESC = 1'b1;
        drain();
    endtask

    function automatic logic [WD-1:0] rand_op();
        case ($urandom_range(0, 3))
            0:       return '0;
            1:       return '1;
            2:       return WD'($urandom_range(0, 3));
            default: return WD'($urandom_range(0, 255));
        endcase
    endfunction

    task automatic test_random();
        logic [WD-1:0] a, b, c;
        logic          d;
        for (int n = 0; n < 40; n++) begin
            a = rand_op(); b = rand_op(); c = rand_op();
            d = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            exp_q.push_back(model(a, b, c, d));
            send(a, b, c, d);
            repeat ($urandom_range(3, 6)) step();
            out_ready = 1'b1;
            drain();
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_basic_latency();
        test_in_ready_window();
        test_desc_and_equal();
        test_backpressure();
        test_reset_midop();
        test_operand_change();
        test_random();
        repeat (3) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
